// File: rtl/ad_pkg.sv
// Shared definitions for the serial ADC block and its downstream consumers.
package ad_pkg;

  localparam int AD_DATA_W = 8;

  typedef enum logic [0:0] {
    AD_AVG_FILL = 1'b0,
    AD_AVG_RUN  = 1'b1
  } ad_avg_state_e;

endpackage

// File: rtl/ad_avg_ram.sv
// Sample window storage: synchronous write, asynchronous read of the same slot,
// so the oldest sample is visible in the cycle it gets overwritten.
module ad_avg_ram #(
  parameter int DATA_W = 8,
  parameter int LOG2_N = 3
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [LOG2_N-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem [2**LOG2_N];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem[addr_i];

endmodule

// File: rtl/ad_avg_filter.sv
// Boxcar average over the last 2^LOG2_N ADC conversions with a valid strobe
// and a hysteretic threshold alarm.
module ad_avg_filter
  import ad_pkg::*;
#(
  parameter int DATA_W = AD_DATA_W,
  parameter int LOG2_N = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              isdone,
  input  logic [DATA_W-1:0] data,
  input  logic [DATA_W-1:0] thr_hi,
  input  logic [DATA_W-1:0] thr_lo,
  output logic [DATA_W-1:0] avg,
  output logic              avg_valid,
  output logic              alarm,
  output logic              filled
);

  localparam int SUM_W = DATA_W + LOG2_N;
  localparam int CNT_W = LOG2_N + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << LOG2_N) - 1);

  ad_avg_state_e     state_q, state_d;
  logic              isdone_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [LOG2_N-1:0] wrPtr_q, wrPtr_d;
  logic [SUM_W-1:0]  sum_q, sum_d;
  logic              pend_q, pend_d;
  logic [DATA_W-1:0] avg_q, avg_d;
  logic              avgValid_q, avgValid_d;
  logic              alarm_q, alarm_d;
  logic              filled_q, filled_d;
  logic [DATA_W-1:0] oldest;
  logic [DATA_W-1:0] avgNew;
  logic              take;
  logic              ramWe;

  assign take = isdone & ~isdone_q;

  ad_avg_ram #(
    .DATA_W(DATA_W),
    .LOG2_N(LOG2_N)
  ) u_ram (
    .clk_i  (clk),
    .we_i   (ramWe),
    .addr_i (wrPtr_q),
    .wdata_i(data),
    .rdata_o(oldest)
  );

  // Accumulator and window bookkeeping; pend marks a take that completes a window.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wrPtr_d = wrPtr_q;
    sum_d   = sum_q;
    pend_d  = 1'b0;
    ramWe   = 1'b0;
    if (take) begin
      ramWe   = 1'b1;
      wrPtr_d = wrPtr_q + LOG2_N'(1);
      unique case (state_q)
        AD_AVG_FILL: begin
          sum_d = sum_q + SUM_W'(data);
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            state_d = AD_AVG_RUN;
            pend_d  = 1'b1;
          end
        end
        AD_AVG_RUN: begin
          sum_d  = sum_q + SUM_W'(data) - SUM_W'(oldest);
          pend_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign avgNew = sum_q[SUM_W-1:LOG2_N];

  // Output stage one edge after the take; set beats clear when thresholds cross.
  always_comb begin
    avg_d      = avg_q;
    avgValid_d = pend_q;
    alarm_d    = alarm_q;
    filled_d   = filled_q;
    if (pend_q) begin
      avg_d    = avgNew;
      filled_d = 1'b1;
      if (avgNew > thr_hi) begin
        alarm_d = 1'b1;
      end else if (avgNew < thr_lo) begin
        alarm_d = 1'b0;
      end
    end
  end

  // isdone_q resets high so a level held across reset release is not taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= AD_AVG_FILL;
      isdone_q   <= 1'b1;
      cnt_q      <= '0;
      wrPtr_q    <= '0;
      sum_q      <= '0;
      pend_q     <= 1'b0;
      avg_q      <= '0;
      avgValid_q <= 1'b0;
      alarm_q    <= 1'b0;
      filled_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      isdone_q   <= isdone;
      cnt_q      <= cnt_d;
      wrPtr_q    <= wrPtr_d;
      sum_q      <= sum_d;
      pend_q     <= pend_d;
      avg_q      <= avg_d;
      avgValid_q <= avgValid_d;
      alarm_q    <= alarm_d;
      filled_q   <= filled_d;
    end
  end

  assign avg       = avg_q;
  assign avg_valid = avgValid_q;
  assign alarm     = alarm_q;
  assign filled    = filled_q;

endmodule
